// File: rtl/adc_mcp3201_avg_core.sv
// adc_mcp3201_avg_core
//   Reads an MCP3201-style SPI ADC one frame per rising edge of latch and keeps
//   a running-sum moving average over the last 2**AVG_LOG2 results.
//   Frame: CS low, LEAD_CLKS+DATA_W SCLK cycles, MSB-first capture on each SCLK
//   rise after the lead bits, then DONE (valid), AVG (latch_dac), RECOV (tCSH).
//
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous reset, active low
//   latch      in   conversion request, rising edge sensitive
//   sdi_adc    in   serial data from the ADC (Dout)
//   cs_adc     out  ADC chip select, active low
//   clk_adc    out  ADC serial clock, idles low
//   value      out  last raw conversion result
//   value_avg  out  moving average of the last 2**AVG_LOG2 results
//   valid      out  1-cycle pulse, value updated
//   latch_dac  out  1-cycle pulse, value_avg updated
//   busy       out  frame in progress or CS recovery running
//   avg_full   out  averaging buffer holds 2**AVG_LOG2 real samples
//   state_dbg  out  current FSM state, for observation only
//
// Handshake: there is no back-pressure. latch is an edge request that is
// accepted only in IDLE; valid and latch_dac are single-cycle strobes that the
// consumer must capture in the cycle they are high.
module adc_mcp3201_avg_core #(
    parameter int DATA_W    = 12,
    parameter int CLK_DIV   = 30,
    parameter int LEAD_CLKS = 3,
    parameter int AVG_LOG2  = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              latch,
    input  logic              sdi_adc,
    output logic              cs_adc,
    output logic              clk_adc,
    output logic [DATA_W-1:0] value,
    output logic [DATA_W-1:0] value_avg,
    output logic              valid,
    output logic              latch_dac,
    output logic              busy,
    output logic              avg_full,
    output logic [2:0]        state_dbg
);

    localparam int NBITS  = LEAD_CLKS + DATA_W;
    localparam int BIT_W  = $clog2(NBITS + 1);
    localparam int DIV_W  = $clog2(2 * CLK_DIV + 1);
    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int PTR_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int FILL_W = AVG_LOG2 + 1;
    localparam int SUM_W  = DATA_W + AVG_LOG2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SHIFT = 3'd1;
    localparam logic [2:0] ST_DONE  = 3'd2;
    localparam logic [2:0] ST_AVG   = 3'd3;
    localparam logic [2:0] ST_RECOV = 3'd4;

    logic [2:0]        state;
    logic              latch_q;
    logic              start;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] avg_buf [DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [FILL_W-1:0] fill;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  sum_next;

    assign start     = latch & ~latch_q;
    assign state_dbg = state;

    // The sum always equals the total of the buffer contents, so swapping the
    // oldest entry for the newest one can never exceed SUM_W bits.
    always_comb begin
        sum_next = sum + SUM_W'(value) - SUM_W'(avg_buf[ptr]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            latch_q   <= 1'b0;
            cs_adc    <= 1'b1;
            clk_adc   <= 1'b0;
            value     <= '0;
            value_avg <= '0;
            valid     <= 1'b0;
            latch_dac <= 1'b0;
            busy      <= 1'b0;
            avg_full  <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            ptr       <= '0;
            fill      <= '0;
            sum       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                avg_buf[i] <= '0;
            end
        end else begin
            latch_q   <= latch;
            valid     <= 1'b0;
            latch_dac <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cs_adc  <= 1'b0;
                        busy    <= 1'b1;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        if (!clk_adc) begin
                            // Rising SCLK: the ADC has held this bit since the
                            // previous falling edge, so sample it now.
                            clk_adc <= 1'b1;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt >= BIT_W'(LEAD_CLKS)) begin
                                shift_reg <= DATA_W'({shift_reg, sdi_adc});
                            end
                        end else begin
                            clk_adc <= 1'b0;
                            if (bit_cnt == BIT_W'(NBITS)) begin
                                cs_adc <= 1'b1;
                                state  <= ST_DONE;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    value <= shift_reg;
                    valid <= 1'b1;
                    state <= ST_AVG;
                end
                ST_AVG: begin
                    sum          <= sum_next;
                    avg_buf[ptr] <= value;
                    ptr          <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
                    // Ramp-up is deliberately not normalised by the fill count.
                    value_avg    <= DATA_W'(sum_next >> AVG_LOG2);
                    latch_dac    <= 1'b1;
                    if (fill != FILL_W'(DEPTH)) begin
                        fill <= fill + 1'b1;
                    end
                    avg_full     <= (fill >= FILL_W'(DEPTH - 1));
                    div_cnt      <= '0;
                    state        <= ST_RECOV;
                end
                ST_RECOV: begin
                    if (div_cnt == DIV_W'(2 * CLK_DIV - 1)) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_mcp3201_avg_core.sv
// tb_adc_mcp3201_avg_core
//   Self-checking bench for adc_mcp3201_avg_core with default parameters.
//   An ADC model serves a 15-bit frame (lead bits + 12-bit word) on clk_adc,
//   changing data after each falling SCLK edge. Expected results are pushed to
//   queues when a frame is requested and popped when valid / latch_dac pulse.
module tb_adc_mcp3201_avg_core;

    localparam int DATA_W  = 12;
    localparam int CLK_DIV = 30;
    localparam int NBITS   = 15;
    localparam int CS_LOW  = 2 * CLK_DIV * NBITS;

    logic              clk;
    logic              reset_n;
    logic              latch;
    logic              sdi_adc;
    logic              cs_adc;
    logic              clk_adc;
    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] value_avg;
    logic              valid;
    logic              latch_dac;
    logic              busy;
    logic              avg_full;
    logic [2:0]        state_dbg;

    adc_mcp3201_avg_core #(
        .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .LEAD_CLKS(3), .AVG_LOG2(3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .latch(latch), .sdi_adc(sdi_adc),
        .cs_adc(cs_adc), .clk_adc(clk_adc), .value(value), .value_avg(value_avg),
        .valid(valid), .latch_dac(latch_dac), .busy(busy), .avg_full(avg_full),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard queues ----------------
    logic [DATA_W-1:0] exp_q[$];      // expected value at valid
    logic [DATA_W:0]   exp_avg_q[$];  // expected {avg_full, value_avg} at latch_dac

    // ---------------- ADC model + monitor ----------------
    logic [NBITS-1:0] adc_frame = '0;
    int  adc_idx   = NBITS;
    int  rise_cnt  = 0;
    int  cs_low_cnt = 0;
    int  valid_cnt = 0;
    logic cs_d = 1'b1, clk_adc_d = 1'b0, valid_d = 1'b0;

    always @(negedge clk) begin
        if (cs_d && !cs_adc) adc_idx = 0;
        else if (clk_adc_d && !clk_adc) adc_idx = adc_idx + 1;
        sdi_adc = (adc_idx < NBITS) ? adc_frame[NBITS-1-adc_idx] : 1'b0;
        if (!clk_adc_d && clk_adc) rise_cnt++;
        if (!cs_adc) cs_low_cnt++;
        if (valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) check("unexpected_valid", 32'(value), 32'hFFFF_FFFF);
            else check("value", 32'(value), 32'(exp_q.pop_front()));
        end
        if (latch_dac) begin
            check("latch_dac_after_valid", 32'(valid_d), 32'd1);
            if (exp_avg_q.size() == 0) check("unexpected_latch_dac", 32'(value_avg), 32'hFFFF_FFFF);
            else check("avg_full_value_avg", 32'({avg_full, value_avg}), 32'(exp_avg_q.pop_front()));
        end
        cs_d      = cs_adc;
        clk_adc_d = clk_adc;
        valid_d   = valid;
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic run_frame(input logic [2:0] lead, input logic [11:0] word,
                             input logic [11:0] e_avg, input logic e_full);
        int r0, c0, v0;
        adc_frame = {lead, word};
        exp_q.push_back(word);
        exp_avg_q.push_back({e_full, e_avg});
        r0 = rise_cnt; c0 = cs_low_cnt; v0 = valid_cnt;
        latch = 1'b1;
        @(negedge clk);
        check("cs_fall_latency", 32'(cs_adc), 32'd0);
        latch = 1'b0;
        wait_idle("frame");
        check("sclk_rises", 32'(rise_cnt - r0), 32'(NBITS));
        check("cs_low_cycles", 32'(cs_low_cnt - c0), 32'(CS_LOW));
        check("valid_count", 32'(valid_cnt - v0), 32'd1);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [2:0]  lead;
        logic [11:0] word;
        logic [11:0] exp_avg;
        logic        exp_full;
    } vec_t;

    vec_t vecs[25];
    logic [11:0] up_avg[8]   = '{12'h8FF, 12'h9FF, 12'hAFF, 12'hBFF, 12'hCFF, 12'hDFF, 12'hEFF, 12'hFFF};
    logic [11:0] down_avg[8] = '{12'hDFF, 12'hBFF, 12'h9FF, 12'h7FF, 12'h5FF, 12'h3FF, 12'h1FF, 12'h000};

    initial begin
        int r0, v0, n;
        // T2: single frame after reset
        vecs[0] = '{3'b000, 12'h801, 12'h100, 1'b0};
        // T3: eight frames of 0x800, lead bits vary to show they are discarded
        for (int k = 0; k < 8; k++)
            vecs[1+k] = '{3'(k), 12'h800, 12'((k + 1) * 256), (k == 7)};
        // T4: eight of 0xFFF then eight of 0x000
        for (int k = 0; k < 8; k++) begin
            vecs[9+k]  = '{3'(7 - k), 12'hFFF, up_avg[k], 1'b1};
            vecs[17+k] = '{3'(k), 12'h000, down_avg[k], 1'b1};
        end

        latch = 1'b0;
        sdi_adc = 1'b0;
        reset_n = 1'b0;

        // T1: reset values
        repeat (3) @(negedge clk);
        check("rst_cs_adc", 32'(cs_adc), 32'd1);
        check("rst_clk_adc", 32'(clk_adc), 32'd0);
        check("rst_value", 32'(value), 32'd0);
        check("rst_value_avg", 32'(value_avg), 32'd0);
        check("rst_strobes", 32'({valid, latch_dac, busy, avg_full}), 32'd0);
        reset_n = 1'b1;
        r0 = rise_cnt;
        repeat (200) @(negedge clk);
        check("idle_no_sclk", 32'(rise_cnt - r0), 32'd0);
        check("idle_cs_high", 32'(cs_adc), 32'd1);

        // T2
        run_frame(vecs[0].lead, vecs[0].word, vecs[0].exp_avg, vecs[0].exp_full);
        // T3, T4 from a clean averager
        do_reset();
        for (int i = 1; i < 25; i++)
            run_frame(vecs[i].lead, vecs[i].word, vecs[i].exp_avg, vecs[i].exp_full);

        // T5: latch held high, then an extra edge while busy
        adc_frame = {3'b000, 12'h5A5};
        exp_q.push_back(12'h5A5);
        exp_avg_q.push_back({1'b1, 12'h0B4});
        r0 = rise_cnt; v0 = valid_cnt;
        latch = 1'b1;
        repeat (500) @(negedge clk);
        latch = 1'b0;
        repeat (20) @(negedge clk);
        latch = 1'b1;
        repeat (20) @(negedge clk);
        latch = 1'b0;
        wait_idle("held");
        repeat (200) @(negedge clk);
        check("held_one_frame_rises", 32'(rise_cnt - r0), 32'(NBITS));
        check("held_one_valid", 32'(valid_cnt - v0), 32'd1);
        check("held_cs_high_after", 32'(cs_adc), 32'd1);

        // T6: reset during the 7th SCLK high phase
        adc_frame = {3'b000, 12'hABC};
        r0 = rise_cnt;
        latch = 1'b1;
        @(negedge clk);
        latch = 1'b0;
        n = 0;
        while ((rise_cnt - r0) < 7 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t6_reach_7th_rise", 32'(rise_cnt - r0), 32'd7);
        repeat (10) @(negedge clk);
        check("t6_sclk_high_before_rst", 32'(clk_adc), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_cs_adc", 32'(cs_adc), 32'd1);
        check("t6_rst_clk_adc", 32'(clk_adc), 32'd0);
        check("t6_rst_busy_value", 32'({busy, value}), 32'd0);
        check("t6_rst_avg_full", 32'(avg_full), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        // Averager was cleared: 0x123 / 8 = 0x24, buffer not full
        run_frame(3'b111, 12'h123, 12'h024, 1'b0);

        repeat (20) @(negedge clk);
        check("sb_value_drained", 32'(exp_q.size()), 32'd0);
        check("sb_avg_drained", 32'(exp_avg_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
